// File: rtl/conv_axil_pkg.sv
// Shared constants, FSM encodings and helpers for the convolution-core AXI4-Lite register file.
// Register indices are word indices, i.e. byte address >> ADDR_LSB.
package conv_axil_pkg;

   localparam int ADDR_LSB   = 2;

   localparam int REG_CTRL   = 0;
   localparam int REG_STATUS = 1;
   localparam int COEF_BASE  = 2;

   localparam int CTRL_START   = 0;
   localparam int CTRL_IRQ_EN  = 1;
   localparam int CTRL_MODE_LO = 2;

   localparam int STATUS_BUSY      = 0;
   localparam int STATUS_DONE      = 1;
   localparam int STATUS_START_ERR = 2;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic {W_IDLE, W_RESP} wr_state_t;
   typedef enum logic {R_IDLE, R_DATA} rd_state_t;

   function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
      logic [31:0] res;
      for (int b = 0; b < 4; b++) begin
         res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/conv_axil_regfile.sv
// AXI4-Lite slave register file for the convolution core: CTRL/STATUS handshake plus
// byte-strobed coefficient registers, with independent AW/W capture and one outstanding write.
module conv_axil_regfile
   import conv_axil_pkg::*;
#(
   parameter int C_S_AXI_DATA_WIDTH = 32,
   parameter int C_S_AXI_ADDR_WIDTH = 6,
   parameter int NUM_REGS           = 16
) (
   input  logic                            S_AXI_ACLK,
   input  logic                            S_AXI_ARESETN,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
   input  logic [2:0]                      S_AXI_AWPROT,
   input  logic                            S_AXI_AWVALID,
   output logic                            S_AXI_AWREADY,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
   input  logic                            S_AXI_WVALID,
   output logic                            S_AXI_WREADY,
   output logic [1:0]                      S_AXI_BRESP,
   output logic                            S_AXI_BVALID,
   input  logic                            S_AXI_BREADY,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
   input  logic [2:0]                      S_AXI_ARPROT,
   input  logic                            S_AXI_ARVALID,
   output logic                            S_AXI_ARREADY,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
   output logic [1:0]                      S_AXI_RRESP,
   output logic                            S_AXI_RVALID,
   input  logic                            S_AXI_RREADY,
   output logic                            conv_start,
   output logic [1:0]                      conv_mode,
   input  logic                            conv_busy,
   input  logic                            conv_done,
   output logic [32*(NUM_REGS-2)-1:0]      coef_o,
   output logic                            irq
);

   localparam int               IDX_W      = C_S_AXI_ADDR_WIDTH - ADDR_LSB;
   localparam int               NUM_COEF   = NUM_REGS - COEF_BASE;
   localparam logic [IDX_W:0]   NUM_REGS_W = (IDX_W+1)'(NUM_REGS);

   wr_state_t          wr_state_reg;
   rd_state_t          rd_state_reg;
   logic               awready_reg, wready_reg, bvalid_reg;
   logic               arready_reg, rvalid_reg;
   logic [1:0]         bresp_reg, rresp_reg;
   logic [31:0]        rdata_reg;
   logic               aw_held_reg, w_held_reg;
   logic [IDX_W-1:0]   awidx_reg;
   logic [31:0]        wdata_reg;
   logic [3:0]         wstrb_reg;

   logic               irq_en_reg, done_reg, start_err_reg, conv_start_reg, irq_reg;
   logic [1:0]         mode_reg;
   logic [31:0]        coef_reg [NUM_COEF];

   logic               aw_hs, w_hs, aw_have, w_have, commit, wr_in_range;
   logic [IDX_W-1:0]   wr_idx;
   logic [31:0]        wr_data;
   logic [3:0]         wr_strb;
   logic               wr_ctrl, start_req, done_clr, err_clr;
   logic [NUM_COEF-1:0] coef_we;

   logic               ar_hs, rd_in_range;
   logic [IDX_W-1:0]   rd_idx;
   logic [31:0]        rd_word;

   // The write commits on the edge that completes the second capture, so use the live channel
   // values for whichever half is being captured in this very cycle.
   always_comb begin
      aw_hs       = awready_reg & S_AXI_AWVALID;
      w_hs        = wready_reg & S_AXI_WVALID;
      aw_have     = aw_held_reg | aw_hs;
      w_have      = w_held_reg | w_hs;
      commit      = (wr_state_reg == W_IDLE) & aw_have & w_have;
      wr_idx      = aw_hs ? S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB] : awidx_reg;
      wr_data     = w_hs ? S_AXI_WDATA[31:0] : wdata_reg;
      wr_strb     = w_hs ? S_AXI_WSTRB[3:0] : wstrb_reg;
      wr_in_range = {1'b0, wr_idx} < NUM_REGS_W;
      wr_ctrl     = commit & (wr_idx == IDX_W'(REG_CTRL));
      start_req   = wr_ctrl & wr_strb[0] & wr_data[CTRL_START];
      done_clr    = commit & (wr_idx == IDX_W'(REG_STATUS)) & wr_strb[0] & wr_data[STATUS_DONE];
      err_clr     = commit & (wr_idx == IDX_W'(REG_STATUS)) & wr_strb[0] & wr_data[STATUS_START_ERR];
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_COEF; gi++) begin : g_coef
         assign coef_we[gi]           = commit & (wr_idx == IDX_W'(COEF_BASE + gi));
         assign coef_o[32*gi +: 32]   = coef_reg[gi];
      end
   endgenerate

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         wr_state_reg   <= W_IDLE;
         awready_reg    <= 1'b0;
         wready_reg     <= 1'b0;
         bvalid_reg     <= 1'b0;
         bresp_reg      <= RESP_OKAY;
         aw_held_reg    <= 1'b0;
         w_held_reg     <= 1'b0;
         awidx_reg      <= '0;
         wdata_reg      <= '0;
         wstrb_reg      <= '0;
         irq_en_reg     <= 1'b0;
         mode_reg       <= '0;
         done_reg       <= 1'b0;
         start_err_reg  <= 1'b0;
         conv_start_reg <= 1'b0;
         irq_reg        <= 1'b0;
         for (int i = 0; i < NUM_COEF; i++) coef_reg[i] <= '0;
      end else begin
         conv_start_reg <= 1'b0;
         irq_reg        <= irq_en_reg & done_reg;
         // Set beats clear when a core event coincides with the W1C write.
         done_reg       <= (done_reg & ~done_clr) | conv_done;
         start_err_reg  <= (start_err_reg & ~err_clr) | (start_req & conv_busy);
         if (start_req & ~conv_busy) conv_start_reg <= 1'b1;
         if (wr_ctrl & wr_strb[0]) begin
            irq_en_reg <= wr_data[CTRL_IRQ_EN];
            mode_reg   <= wr_data[CTRL_MODE_LO +: 2];
         end
         for (int i = 0; i < NUM_COEF; i++) begin
            if (coef_we[i]) coef_reg[i] <= apply_strb(coef_reg[i], wr_data, wr_strb);
         end

         case (wr_state_reg)
            W_IDLE: begin
               if (aw_hs) begin
                  awidx_reg   <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
                  aw_held_reg <= 1'b1;
               end
               if (w_hs) begin
                  wdata_reg  <= S_AXI_WDATA[31:0];
                  wstrb_reg  <= S_AXI_WSTRB[3:0];
                  w_held_reg <= 1'b1;
               end
               if (commit) begin
                  wr_state_reg <= W_RESP;
                  bvalid_reg   <= 1'b1;
                  bresp_reg    <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
                  awready_reg  <= 1'b0;
                  wready_reg   <= 1'b0;
               end else begin
                  awready_reg  <= ~aw_have;
                  wready_reg   <= ~w_have;
               end
            end
            W_RESP: begin
               if (S_AXI_BREADY) begin
                  wr_state_reg <= W_IDLE;
                  bvalid_reg   <= 1'b0;
                  aw_held_reg  <= 1'b0;
                  w_held_reg   <= 1'b0;
                  awready_reg  <= 1'b1;
                  wready_reg   <= 1'b1;
               end
            end
            default: wr_state_reg <= W_IDLE;
         endcase
      end
   end

   always_comb begin
      ar_hs       = arready_reg & S_AXI_ARVALID;
      rd_idx      = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:ADDR_LSB];
      rd_in_range = {1'b0, rd_idx} < NUM_REGS_W;
      rd_word     = '0;
      if (rd_idx == IDX_W'(REG_CTRL)) begin
         rd_word[CTRL_IRQ_EN]       = irq_en_reg;
         rd_word[CTRL_MODE_LO +: 2] = mode_reg;
      end
      if (rd_idx == IDX_W'(REG_STATUS)) begin
         rd_word[STATUS_BUSY]      = conv_busy;
         rd_word[STATUS_DONE]      = done_reg;
         rd_word[STATUS_START_ERR] = start_err_reg;
      end
      for (int i = 0; i < NUM_COEF; i++) begin
         if (rd_idx == IDX_W'(COEF_BASE + i)) rd_word = coef_reg[i];
      end
   end

   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         rd_state_reg <= R_IDLE;
         arready_reg  <= 1'b0;
         rvalid_reg   <= 1'b0;
         rresp_reg    <= RESP_OKAY;
         rdata_reg    <= '0;
      end else begin
         case (rd_state_reg)
            R_IDLE: begin
               if (ar_hs) begin
                  rd_state_reg <= R_DATA;
                  arready_reg  <= 1'b0;
                  rvalid_reg   <= 1'b1;
                  rdata_reg    <= rd_word;
                  rresp_reg    <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
               end else begin
                  arready_reg  <= 1'b1;
               end
            end
            R_DATA: begin
               if (S_AXI_RREADY) begin
                  rd_state_reg <= R_IDLE;
                  rvalid_reg   <= 1'b0;
                  arready_reg  <= 1'b1;
               end
            end
            default: rd_state_reg <= R_IDLE;
         endcase
      end
   end

   logic unused_ok;
   assign unused_ok = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                        S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0]};

   assign S_AXI_AWREADY = awready_reg;
   assign S_AXI_WREADY  = wready_reg;
   assign S_AXI_BVALID  = bvalid_reg;
   assign S_AXI_BRESP   = bresp_reg;
   assign S_AXI_ARREADY = arready_reg;
   assign S_AXI_RVALID  = rvalid_reg;
   assign S_AXI_RRESP   = rresp_reg;
   assign S_AXI_RDATA   = C_S_AXI_DATA_WIDTH'(rdata_reg);
   assign conv_start    = conv_start_reg;
   assign conv_mode     = mode_reg;
   assign irq           = irq_reg;

endmodule

// File: tb/tb_conv_axil_regfile.sv
// Self-checking bench for conv_axil_regfile (7-bit address, 16 registers) against a word-level
// model of the register map; one line is printed per AXI transaction.
module tb_conv_axil_regfile;

   localparam int AW = 7;
   localparam int NR = 16;
   localparam int NC = NR - 2;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [AW-1:0]   awaddr = '0;
   logic [2:0]      awprot = '0;
   logic            awvalid = 1'b0;
   logic            awready;
   logic [31:0]     wdata = '0;
   logic [3:0]      wstrb = '0;
   logic            wvalid = 1'b0;
   logic            wready;
   logic [1:0]      bresp;
   logic            bvalid;
   logic            bready = 1'b0;
   logic [AW-1:0]   araddr = '0;
   logic [2:0]      arprot = '0;
   logic            arvalid = 1'b0;
   logic            arready;
   logic [31:0]     rdata;
   logic [1:0]      rresp;
   logic            rvalid;
   logic            rready = 1'b0;
   logic            conv_start;
   logic [1:0]      conv_mode;
   logic            conv_busy = 1'b0;
   logic            conv_done = 1'b0;
   logic [32*NC-1:0] coef_o;
   logic            irq;

   int n_cmp = 0;
   int n_err = 0;
   int start_cnt = 0;
   int bhs_cnt = 0;
   logic [31:0] mdl [NR];

   conv_axil_regfile #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(AW), .NUM_REGS(NR)) dut (
      .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
      .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
      .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
      .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
      .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
      .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
      .conv_start(conv_start), .conv_mode(conv_mode), .conv_busy(conv_busy), .conv_done(conv_done),
      .coef_o(coef_o), .irq(irq)
   );

   always #5 clk = ~clk;

   // Inputs change 1ns after posedge, so the negedge view is exactly what the next edge will see.
   always @(negedge clk) begin
      if (conv_start) start_cnt++;
      if (bvalid && bready) bhs_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: sim time limit hit, required bench completion");
      $fatal(1, "watchdog expired");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Reference model of the register map, per word.
   function automatic void mdl_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
      int idx;
      idx = int'(a[AW-1:2]);
      if (idx >= NR) return;
      if (idx == 0) begin
         if (s[0]) begin
            mdl[0] = {28'd0, d[3:1], 1'b0};
            if (d[0] && conv_busy) mdl[1][2] = 1'b1;
         end
      end else if (idx == 1) begin
         if (s[0]) mdl[1] = mdl[1] & ~(d & 32'h6);
      end else begin
         for (int b = 0; b < 4; b++) if (s[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
      end
   endfunction

   function automatic logic [31:0] mdl_read(input logic [AW-1:0] a);
      int idx;
      idx = int'(a[AW-1:2]);
      if (idx >= NR) return 32'h0;
      if (idx == 1) return mdl[1] | {31'd0, conv_busy};
      return mdl[idx];
   endfunction

   function automatic logic [1:0] mdl_resp(input logic [AW-1:0] a);
      return (int'(a[AW-1:2]) >= NR) ? 2'b10 : 2'b00;
   endfunction

   task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [1:0] resp);
      int cyc;
      bit aw_hs, w_hs, got;
      tick();
      awaddr = a; awvalid = 1'b1; wdata = d; wstrb = s; wvalid = 1'b1; bready = 1'b1;
      cyc = 0;
      while ((awvalid || wvalid) && cyc < 40) begin
         @(negedge clk);
         aw_hs = awvalid && awready;
         w_hs  = wvalid && wready;
         tick();
         if (aw_hs) awvalid = 1'b0;
         if (w_hs)  wvalid  = 1'b0;
         cyc++;
      end
      got = 1'b0;
      resp = 2'bxx;
      while (!got && cyc < 80) begin
         @(negedge clk);
         if (bvalid) begin got = 1'b1; resp = bresp; end
         tick();
         cyc++;
      end
      awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
      n_cmp++;
      if (!got) begin
         n_err++;
         $display("FAIL wr_timeout: addr %02h bvalid=0, required a write response", a);
      end
      $display("WR addr=%02h data=%08h strb=%h resp=%0d", a, d, s, resp);
   endtask

   task automatic axi_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] resp);
      int cyc;
      bit ar_hs, got;
      tick();
      araddr = a; arvalid = 1'b1; rready = 1'b1;
      cyc = 0;
      while (arvalid && cyc < 40) begin
         @(negedge clk);
         ar_hs = arvalid && arready;
         tick();
         if (ar_hs) arvalid = 1'b0;
         cyc++;
      end
      got = 1'b0;
      d = 'x;
      resp = 2'bxx;
      while (!got && cyc < 80) begin
         @(negedge clk);
         if (rvalid) begin got = 1'b1; d = rdata; resp = rresp; end
         tick();
         cyc++;
      end
      arvalid = 1'b0; rready = 1'b0;
      n_cmp++;
      if (!got) begin
         n_err++;
         $display("FAIL rd_timeout: addr %02h rvalid=0, required read data", a);
      end
      $display("RD addr=%02h data=%08h resp=%0d", a, d, resp);
   endtask

   task automatic pulse_done;
      tick();
      conv_done = 1'b1;
      tick();
      conv_done = 1'b0;
      mdl[1][1] = 1'b1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      for (int i = 0; i < NR; i++) mdl[i] = '0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({awready, wready, arready, bvalid, rvalid, conv_start, irq} !== 7'b0) begin
         n_err++;
         $display("FAIL reset_ctrl: got %b, required 0000000",
                  {awready, wready, arready, bvalid, rvalid, conv_start, irq});
      end
      n_cmp++;
      if ({bresp, rresp, rdata} !== 36'h0) begin
         n_err++;
         $display("FAIL reset_resp: got bresp=%0d rresp=%0d rdata=%08h, required 0", bresp, rresp, rdata);
      end
      n_cmp++;
      if (coef_o !== '0 || conv_mode !== 2'b00) begin
         n_err++;
         $display("FAIL reset_regs: got coef_o=%h mode=%0d, required 0", coef_o, conv_mode);
      end
      tick();
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({awready, wready, arready} !== 3'b111) begin
         n_err++;
         $display("FAIL ready_after_reset: got %b, required 111", {awready, wready, arready});
      end
   endtask

   task automatic test_coef_rw;
      logic [1:0] resp;
      logic [31:0] d;
      for (int r = 2; r < NR; r++) begin
         axi_write(AW'(r * 4), 32'(r - 1), 4'hF, resp);
         mdl_write(AW'(r * 4), 32'(r - 1), 4'hF);
         n_cmp++;
         if (resp !== 2'b00) begin n_err++; $display("FAIL coef_bresp: reg %0d got %0d, required 0", r, resp); end
      end
      for (int r = 2; r < NR; r++) begin
         axi_read(AW'(r * 4), d, resp);
         n_cmp++;
         if (d !== mdl_read(AW'(r * 4)) || resp !== 2'b00) begin
            n_err++;
            $display("FAIL coef_read: reg %0d got %08h/%0d, required %08h/0", r, d, resp, mdl_read(AW'(r * 4)));
         end
      end
      n_cmp++;
      if (coef_o[31:0] !== 32'h1) begin n_err++; $display("FAIL coef_o_lsb: got %08h, required 00000001", coef_o[31:0]); end
   endtask

   task automatic test_strobe;
      logic [1:0] resp;
      logic [31:0] d;
      axi_write(7'h08, 32'hAABBCCDD, 4'hF, resp);
      mdl_write(7'h08, 32'hAABBCCDD, 4'hF);
      axi_write(7'h08, 32'h11223344, 4'b0101, resp);
      mdl_write(7'h08, 32'h11223344, 4'b0101);
      axi_read(7'h08, d, resp);
      n_cmp++;
      if (d !== 32'hAA22CC44) begin n_err++; $display("FAIL strobe_merge: got %08h, required aa22cc44", d); end
   endtask

   task automatic test_w_before_aw;
      logic [31:0] d, exp_d;
      logic [1:0] resp;
      bit hs;
      int b0;
      exp_d = $urandom;
      b0 = bhs_cnt;
      tick();
      wdata = exp_d; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
      @(negedge clk);
      hs = wready;
      tick();
      wvalid = 1'b0;
      repeat (2) tick();
      @(negedge clk);
      n_cmp++;
      if (!hs || {bvalid, wready, awready} !== 3'b001) begin
         n_err++;
         $display("FAIL w_first_hold: w_hs=%0d got bvalid/wready/awready=%b, required 001", hs, {bvalid, wready, awready});
      end
      tick();
      awaddr = 7'h14; awvalid = 1'b1;
      @(negedge clk);
      hs = awready;
      tick();
      awvalid = 1'b0;
      mdl_write(7'h14, exp_d, 4'hF);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         n_cmp++;
         if (!hs || bvalid !== 1'b1 || bresp !== 2'b00) begin
            n_err++;
            $display("FAIL b_stall: cycle %0d got bvalid=%0d bresp=%0d, required 1/0", c, bvalid, bresp);
         end
      end
      tick();
      bready = 1'b1;
      tick();
      bready = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bvalid !== 1'b0 || bhs_cnt - b0 != 1) begin
         n_err++;
         $display("FAIL b_single: got bvalid=%0d handshakes=%0d, required 0/1", bvalid, bhs_cnt - b0);
      end
      axi_read(7'h14, d, resp);
      n_cmp++;
      if (d !== exp_d) begin n_err++; $display("FAIL w_first_data: got %08h, required %08h", d, exp_d); end
   endtask

   task automatic test_start_done;
      logic [1:0] resp;
      logic [31:0] d;
      int s0;
      conv_busy = 1'b0;
      s0 = start_cnt;
      axi_write(7'h00, 32'h3, 4'hF, resp);
      mdl_write(7'h00, 32'h3, 4'hF);
      n_cmp++;
      if (start_cnt - s0 != 1) begin n_err++; $display("FAIL start_pulse: got %0d cycles high, required 1", start_cnt - s0); end
      pulse_done();
      repeat (2) @(negedge clk);
      n_cmp++;
      if (irq !== 1'b1) begin n_err++; $display("FAIL irq_set: got %0d, required 1", irq); end
      axi_read(7'h04, d, resp);
      n_cmp++;
      if (d !== 32'h2) begin n_err++; $display("FAIL status_done: got %08h, required 00000002", d); end
      axi_write(7'h04, 32'h2, 4'hF, resp);
      mdl_write(7'h04, 32'h2, 4'hF);
      @(negedge clk);
      n_cmp++;
      if (irq !== 1'b0) begin n_err++; $display("FAIL irq_clear: got %0d, required 0", irq); end
      axi_read(7'h04, d, resp);
      n_cmp++;
      if (d !== mdl_read(7'h04)) begin n_err++; $display("FAIL status_w1c: got %08h, required %08h", d, mdl_read(7'h04)); end
   endtask

   task automatic test_start_err;
      logic [1:0] resp;
      logic [31:0] d;
      int s0;
      conv_busy = 1'b1;
      s0 = start_cnt;
      axi_write(7'h00, 32'h3, 4'hF, resp);
      mdl_write(7'h00, 32'h3, 4'hF);
      n_cmp++;
      if (start_cnt != s0) begin n_err++; $display("FAIL start_busy: got %0d pulses, required 0", start_cnt - s0); end
      axi_read(7'h04, d, resp);
      n_cmp++;
      if (d !== 32'h5) begin n_err++; $display("FAIL start_err: got %08h, required 00000005", d); end
      conv_busy = 1'b0;
      pulse_done();
      // W1C of DONE lands on the same edge as a fresh conv_done.
      tick();
      awaddr = 7'h04; wdata = 32'h2; wstrb = 4'h1; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
      conv_done = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (!(awready && wready)) begin n_err++; $display("FAIL coincide_ready: got aw/w=%b, required 11", {awready, wready}); end
      tick();
      awvalid = 1'b0; wvalid = 1'b0; conv_done = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (bvalid !== 1'b1) begin n_err++; $display("FAIL coincide_bvalid: got %0d, required 1", bvalid); end
      tick();
      bready = 1'b0;
      axi_read(7'h04, d, resp);
      n_cmp++;
      if (d !== 32'h6) begin n_err++; $display("FAIL done_set_wins: got %08h, required 00000006", d); end
      axi_write(7'h04, 32'h6, 4'h1, resp);
      mdl_write(7'h04, 32'h6, 4'h1);
      axi_read(7'h04, d, resp);
      n_cmp++;
      if (d !== 32'h0) begin n_err++; $display("FAIL status_clear_all: got %08h, required 0", d); end
   endtask

   task automatic test_slverr;
      logic [1:0] resp;
      logic [31:0] d;
      axi_write(7'h40, $urandom, 4'hF, resp);
      n_cmp++;
      if (resp !== 2'b10) begin n_err++; $display("FAIL slverr_bresp: got %0d, required 2", resp); end
      axi_read(7'h40, d, resp);
      n_cmp++;
      if (d !== 32'h0 || resp !== 2'b10) begin n_err++; $display("FAIL slverr_read: got %08h/%0d, required 0/2", d, resp); end
      axi_read(7'h08, d, resp);
      n_cmp++;
      if (d !== mdl_read(7'h08)) begin n_err++; $display("FAIL slverr_nochange: got %08h, required %08h", d, mdl_read(7'h08)); end
   endtask

   task automatic test_random;
      logic [AW-1:0] a;
      logic [31:0] d, got;
      logic [3:0] s;
      logic [1:0] resp;
      int s0;
      conv_busy = 1'b0;
      for (int t = 0; t < 60; t++) begin
         a = AW'($urandom_range(0, NR + 1) * 4);
         if ($urandom_range(0, 1) == 1) begin
            d = $urandom;
            s = 4'($urandom);
            s0 = start_cnt;
            axi_write(a, d, s, resp);
            n_cmp++;
            if (resp !== mdl_resp(a) || (start_cnt - s0) != ((a == 7'h00 && s[0] && d[0]) ? 1 : 0)) begin
               n_err++;
               $display("FAIL rand_write: addr %02h got resp=%0d starts=%0d, required resp=%0d", a, resp, start_cnt - s0, mdl_resp(a));
            end
            mdl_write(a, d, s);
         end else begin
            axi_read(a, got, resp);
            n_cmp++;
            if (got !== mdl_read(a) || resp !== mdl_resp(a)) begin
               n_err++;
               $display("FAIL rand_read: addr %02h got %08h/%0d, required %08h/%0d", a, got, resp, mdl_read(a), mdl_resp(a));
            end
         end
      end
      @(negedge clk);
      n_cmp++;
      if (conv_mode !== mdl[0][3:2]) begin n_err++; $display("FAIL rand_mode: got %0d, required %0d", conv_mode, mdl[0][3:2]); end
      for (int r = 2; r < NR; r++) begin
         n_cmp++;
         if (coef_o[32*(r-2) +: 32] !== mdl[r]) begin
            n_err++;
            $display("FAIL rand_coef_o: reg %0d got %08h, required %08h", r, coef_o[32*(r-2) +: 32], mdl[r]);
         end
      end
   endtask

   task automatic test_reset_mid_read;
      logic [31:0] d;
      logic [1:0] resp;
      tick();
      araddr = 7'h08; arvalid = 1'b1; rready = 1'b0;
      @(negedge clk);
      tick();
      arvalid = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (rvalid !== 1'b1) begin n_err++; $display("FAIL mid_read_valid: got %0d, required 1", rvalid); end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if (rvalid !== 1'b0 || arready !== 1'b0 || coef_o !== '0) begin
         n_err++;
         $display("FAIL mid_read_reset: got rvalid=%0d arready=%0d coef_zero=%0d, required 0/0/1", rvalid, arready, coef_o == '0);
      end
      for (int i = 0; i < NR; i++) mdl[i] = '0;
      tick();
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      axi_read(7'h00, d, resp);
      n_cmp++;
      if (d !== 32'h0 || resp !== 2'b00) begin n_err++; $display("FAIL post_reset_ctrl: got %08h/%0d, required 0/0", d, resp); end
   endtask

   initial begin
      test_reset();
      test_coef_rw();
      test_strobe();
      test_w_before_aw();
      test_start_done();
      test_start_err();
      test_slverr();
      test_random();
      test_reset_mid_read();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
